// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the fetch PC, drives the imem read handshake,
// presents words to decode, and handles branch redirect/squash and halt/resume.
module fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] pc,
    input  logic        br_valid,
    input  logic [15:0] br_cond,
    input  logic [15:0] br_target,
    input  logic        halt,
    output logic        halted
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

    state_t      state, state_nxt;
    logic [15:0] fetch_addr, fetch_nxt, addr_nxt, instr_nxt, pc_nxt;
    logic        squash, squash_nxt;
    logic        taken;

    assign taken = br_valid && (br_cond != 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake outputs are flopped from the next state so nothing input-driven reaches a port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr  <= RESET_VECTOR;
            imem_addr   <= RESET_VECTOR;
            pc          <= RESET_VECTOR;
            instr       <= 16'h0000;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            fetch_addr  <= fetch_nxt;
            imem_addr   <= addr_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            squash      <= squash_nxt;
            imem_req    <= (state_nxt == FETCH);
            instr_valid <= (state_nxt == HOLD);
            halted      <= (state_nxt == HALTED);
        end
    end

    always_comb begin
        state_nxt  = state;
        fetch_nxt  = fetch_addr;
        addr_nxt   = imem_addr;
        instr_nxt  = instr;
        pc_nxt     = pc;
        squash_nxt = squash;
        case (state)
            IDLE: begin
                if (halt) begin
                    state_nxt = HALTED;
                end else begin
                    state_nxt = FETCH;
                    addr_nxt  = fetch_addr;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (squash || taken) begin
                        // Wrong-path word: drop it and reissue at the redirect address.
                        squash_nxt = 1'b0;
                        fetch_nxt  = taken ? br_target : fetch_addr;
                        addr_nxt   = fetch_nxt;
                    end else begin
                        instr_nxt = imem_data;
                        pc_nxt    = imem_addr;
                        fetch_nxt = imem_addr + 16'd1;
                        state_nxt = HOLD;
                    end
                end else if (taken) begin
                    fetch_nxt  = br_target;
                    squash_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (taken) begin
                    fetch_nxt = br_target;
                    addr_nxt  = br_target;
                    state_nxt = FETCH;
                end else if (instr_ready) begin
                    if (halt) begin
                        state_nxt = HALTED;
                    end else begin
                        state_nxt = FETCH;
                        addr_nxt  = fetch_addr;
                    end
                end
            end
            HALTED: begin
                if (taken) fetch_nxt = br_target;
                if (!halt) begin
                    state_nxt = FETCH;
                    addr_nxt  = fetch_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: wait-state memory model, accepted-word scoreboard,
// table of halted-redirect streams and hand sequences for squash, HOLD branch and reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [15:0] pc;
    logic        br_valid = 1'b0;
    logic [15:0] br_cond = 16'h0000;
    logic [15:0] br_target = 16'h0000;
    logic        halt = 1'b0;
    logic        halted;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_VECTOR(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
        .halt(halt), .halted(halted)
    );

    typedef struct {
        logic [15:0] target;
        logic [15:0] nt_target;
        int          delay;
        int          n;
    } vec_t;

    vec_t        tbl[4];
    int          vectors = 0;
    int          miscompares = 0;
    int          acc_cnt = 0;
    logic [15:0] exp_q[$];
    int          ack_delay = 0;
    int          cnt = 0;
    logic        was_req = 1'b0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Memory: ack after ack_delay wait cycles of each request.
    always @(posedge clk) begin
        #1;
        if (!imem_req) begin
            cnt = 0;
            imem_ack = (ack_delay == 0);
        end else begin
            if (!was_req || imem_ack) cnt = 0;
            else                      cnt++;
            imem_ack = (cnt >= ack_delay);
        end
        imem_data = memf(imem_addr);
        was_req = imem_req;
    end

    // Scoreboard: compare each word decode is about to accept.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !(br_valid && br_cond != 16'h0000)) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got pc %h, expected no word", pc);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("acc_pc", pc, e);
                chk("acc_instr", instr, memf(e));
            end
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0:       return imem_req;
            1:       return instr_valid;
            default: return halted;
        endcase
    endfunction

    task automatic wait_for(input string name, input int w, input int budget);
        int n = 0;
        @(negedge clk);
        while (!sel(w) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!sel(w)) begin
            miscompares++;
            $display("FAIL %s: still 0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    task automatic stream_then_halt(input string name, input int n);
        int base = acc_cnt;
        int k = 0;
        while (acc_cnt < base + n - 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1 halt = 1'b1;
        wait_for(name, 2, 200);
        chk({name, "_req"}, 16'(imem_req), 16'd0);
        repeat (3) @(negedge clk);
        chk({name, "_idle_req"}, 16'(imem_req), 16'd0);
        chk({name, "_idle_valid"}, 16'(instr_valid), 16'd0);
        chk({name, "_drain"}, 16'(exp_q.size()), 16'd0);
    endtask

    task automatic branch_halted(input logic [15:0] t, input logic [15:0] nt);
        @(posedge clk); #1 br_valid = 1'b1; br_cond = 16'h0001; br_target = t;
        @(posedge clk); #1 br_cond = 16'h0000; br_target = nt;
        @(posedge clk); #1 br_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h0300, 16'h0BAD, 0, 2};
        tbl[1] = '{16'hFFFF, 16'h1111, 0, 3};
        tbl[2] = '{16'h1234, 16'h2222, 2, 2};
        tbl[3] = '{16'h8000, 16'h3333, 1, 1};

        repeat (3) @(negedge clk);
        chk("rst_req", 16'(imem_req), 16'd0);
        chk("rst_valid", 16'(instr_valid), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_pc", pc, 16'h0100);
        chk("rst_addr", imem_addr, 16'h0100);

        for (int k = 0; k < 5; k++) exp_q.push_back(16'(16'h0100 + k));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req", 16'(imem_req), 16'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_req", 16'(imem_req), 16'd1);
            chk("seq_addr", imem_addr, 16'(16'h0100 + k));
            chk("seq_novalid", 16'(instr_valid), 16'd0);
            @(negedge clk);
            chk("seq_valid", 16'(instr_valid), 16'd1);
            chk("seq_noreq", 16'(imem_req), 16'd0);
        end
        @(posedge clk); #1 halt = 1'b1;
        stream_then_halt("seq_halt", 1);

        // Redirects while halted, with not-taken noise, then bounded streams.
        for (int i = 0; i < 4; i++) begin
            ack_delay = tbl[i].delay;
            branch_halted(tbl[i].target, tbl[i].nt_target);
            for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(16'(tbl[i].target + j));
            halt = 1'b0;
            wait_for("tbl_req", 0, 20);
            chk("tbl_first_addr", imem_addr, tbl[i].target);
            stream_then_halt("tbl_halt", tbl[i].n);
        end

        // Branch during a waited fetch: hold address, discard data, refetch at target.
        begin
            logic saw_valid;
            int   k;
            saw_valid = 1'b0;
            k = 0;
            ack_delay = 3;
            branch_halted(16'h0500, 16'h0666);
            exp_q.push_back(16'h0040);
            halt = 1'b0;
            @(posedge clk); #1 halt = 1'b1;
            wait_for("sq_req", 0, 20);
            chk("sq_addr0", imem_addr, 16'h0500);
            @(posedge clk); #1 br_valid = 1'b1; br_cond = 16'h0001; br_target = 16'h0040;
            @(negedge clk);
            chk("sq_addr1", imem_addr, 16'h0500);
            @(posedge clk); #1 br_valid = 1'b0;
            while (imem_addr == 16'h0500 && k < 10) begin
                @(negedge clk);
                if (instr_valid) saw_valid = 1'b1;
                k++;
            end
            chk("sq_new_addr", imem_addr, 16'h0040);
            chk("sq_new_req", 16'(imem_req), 16'd1);
            chk("sq_no_valid", 16'(saw_valid), 16'd0);
            wait_for("sq_halted", 2, 50);
            chk("sq_drain", 16'(exp_q.size()), 16'd0);
        end

        // HOLD: taken branch beats ready; then not-taken branch accepts normally.
        ack_delay = 0;
        instr_ready = 1'b0;
        branch_halted(16'h0600, 16'h0777);
        halt = 1'b0;
        wait_for("hb_hold", 1, 20);
        chk("hb_pc", pc, 16'h0600);
        @(posedge clk); #1 br_valid = 1'b1; br_cond = 16'h0001; br_target = 16'h0200; instr_ready = 1'b1;
        @(posedge clk); #1 br_valid = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        chk("hb_req", 16'(imem_req), 16'd1);
        chk("hb_addr", imem_addr, 16'h0200);
        chk("hb_novalid", 16'(instr_valid), 16'd0);
        wait_for("hb_hold2", 1, 20);
        chk("hb_pc2", pc, 16'h0200);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0201);
        @(posedge clk); #1 br_valid = 1'b1; br_cond = 16'h0000; br_target = 16'h0AAA; instr_ready = 1'b1;
        @(posedge clk); #1 br_valid = 1'b0; halt = 1'b1;
        @(negedge clk);
        chk("nt_req", 16'(imem_req), 16'd1);
        chk("nt_addr", imem_addr, 16'h0201);
        wait_for("nt_halted", 2, 20);
        chk("nt_drain", 16'(exp_q.size()), 16'd0);

        // Reset during a pending request, then during HOLD.
        ack_delay = 5;
        instr_ready = 1'b1;
        branch_halted(16'h0700, 16'h0888);
        halt = 1'b0;
        wait_for("rr_req", 0, 20);
        chk("rr_addr", imem_addr, 16'h0700);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_req_low", 16'(imem_req), 16'd0);
        chk("rr_pc", pc, 16'h0100);
        chk("rr_addr_rst", imem_addr, 16'h0100);
        @(posedge clk);
        @(posedge clk); #1 ack_delay = 0; instr_ready = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("rr_idle", 16'(imem_req), 16'd0);
        @(negedge clk);
        chk("rr_req2", 16'(imem_req), 16'd1);
        chk("rr_addr2", imem_addr, 16'h0100);
        wait_for("rr_hold", 1, 20);
        chk("rr_hold_pc", pc, 16'h0100);
        chk("rr_hold_instr", instr, memf(16'h0100));
        #2 rst_n = 1'b0;
        #1;
        chk("rv_valid_low", 16'(instr_valid), 16'd0);
        chk("rv_instr", instr, 16'h0000);
        chk("rv_pc", pc, 16'h0100);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b1; instr_ready = 1'b1;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0101);
        stream_then_halt("rv_restart", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller for the 16-bit core: owns the fetch program counter and drives the instruction-memory read handshake. It presents each fetched word to decode over a valid/ready handshake and applies branch redirects with squash of wrong-path fetches. It also provides halt/resume at instruction boundaries. It sits between instruction memory and the decode stage and replaces ad-hoc incr/ce sequencing of the PC.

## Interface
- `RESET_VECTOR`, default 16'h0000: first fetch address after reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: read request to instruction memory.
- `imem_addr` out 16: read address; stable while `imem_req`=1 until ack.
- `imem_ack` in 1: read completes on any edge where `imem_req`=1 and `imem_ack`=1; may be high in the first request cycle.
- `imem_data` in 16: read data, valid with `imem_ack`.
- `instr` out 16: held instruction word.
- `instr_valid` out 1: `instr`/`pc` valid for decode.
- `instr_ready` in 1: decode accepts on edge with `instr_valid`=1 and `instr_ready`=1.
- `pc` out 16: address of the word in `instr`.
- `br_valid` in 1: branch resolved this cycle.
- `br_cond` in 16: branch taken when `br_valid`=1 and `br_cond`≠0.
- `br_target` in 16: redirect address.
- `halt` in 1: level request to stop fetching.
- `halted` out 1: high in HALTED state.

## Operation
- Registers: `fetch_addr` (next address to fetch), `imem_addr`, `instr`, `pc`, `squash` flag, state.
- States: IDLE, FETCH, HOLD, HALTED.
- IDLE: one cycle after reset release. Goes to HALTED if `halt`=1, else FETCH with `imem_addr`<=`fetch_addr`.
- FETCH: `imem_req`=1. On ack with `squash`=0 and no taken branch: `instr`<=`imem_data`, `pc`<=`imem_addr`, `fetch_addr`<=`imem_addr`+1 (mod 2^16, FFFF wraps to 0000), go to HOLD.
- Taken branch in FETCH, no ack: `fetch_addr`<=`br_target`, `squash`<=1. Request stays outstanding with `imem_addr` unchanged.
- Ack with `squash`=1, or ack coinciding with a taken branch: data discarded, `squash`<=0. Stay in FETCH with a new request: `imem_addr`<=target (the new `fetch_addr`), `imem_req` stays 1.
- HOLD: `instr_valid`=1.
  - Taken branch: `instr_valid` drops, `fetch_addr`<=`br_target`, go to FETCH. The branch wins over a simultaneous `instr_ready`; the word is dropped.
  - Handshake without branch: go to HALTED if `halt`=1, else FETCH.
- HALTED: `imem_req`=0, `instr_valid`=0, `halted`=1.
  - Taken branch updates `fetch_addr` only.
  - `halt`=0 goes to FETCH.
- `halt` never aborts an outstanding request or a held instruction. It is honoured only at the IDLE/HOLD exit.
- Not-taken branch (`br_cond`=0) has no effect in any state.

## Timing
- Reset values:
  - `imem_req`=0, `instr_valid`=0, `halted`=0, `instr`=0.
  - `imem_addr`=`pc`=`fetch_addr`=RESET_VECTOR, `squash`=0, state IDLE.
- Reset mid-request drops `imem_req` immediately; a late ack after reset is ignored by the fetch path.
- First `imem_req` appears in the 2nd cycle after `rst_n` rises.
- Zero-wait memory (ack in the first request cycle): `instr_valid` rises the cycle after the ack edge.
- Throughput is 2 cycles/instruction at best (FETCH 1 + HOLD 1).
- Taken-branch penalty from HOLD: `imem_req` at `br_target` the next cycle.
- All outputs are registered; no combinational paths from inputs to outputs.

## Test plan
- Reset RESET_VECTOR=16'h0100, ack always high, ready always high -> `imem_addr` 0100, 0101, 0102…; `instr_valid` every 2nd cycle; `pc` matches each word.
- `fetch_addr`=16'hFFFF via branch -> fetch FFFF, then 0000 (wrap).
- Memory with 3-cycle ack delay; taken branch to 16'h0040 in 2nd wait cycle -> `imem_addr` held until ack, data discarded, next request at 0040, no `instr_valid` for the squashed word.
- In HOLD, `br_valid`=1, `br_cond`=16'h0001, target 16'h0200, same cycle `instr_ready`=1 -> word dropped, next fetch 0200. Repeat with `br_cond`=0 -> normal accept, next fetch `pc`+1.
- `halt`=1 while FETCH pending -> ack completes, word delivered, then `halted`=1 with no new request. Branch to 16'h0300 while halted, then `halt`=0 -> fetch 0300.
- Assert `rst_n`=0 with `imem_req`=1 and `instr_valid`=1 -> both low immediately, `pc`=RESET_VECTOR, restart sequence as in the first case.
